// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one combinational instruction-ROM read port between instruction
// fetch (priority) and the constant-load data path. A data request that has
// been refused MAX_DATA_WAIT consecutive cycles is forced to win. The ROM
// output is registered, so each port gets its response one cycle after its
// grant. Misaligned data requests are answered with an error and make no
// ROM access.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   if_req/if_addr          fetch request, byte address ([1:0] ignored)
//   if_gnt                  fetch accepted this cycle (combinational)
//   if_flush                drop the response of a fetch granted this cycle
//   if_rvalid/if_rdata      fetch response
//   d_req/d_addr            data request, byte address
//   d_gnt                   data accepted this cycle (combinational)
//   d_rvalid/d_rdata/d_err  data response; d_err flags a misaligned address
//   rom_address/rom_data    ROM read port
module rom_port_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int MAX_DATA_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_data
);

  localparam int CNT_W = (MAX_DATA_WAIT < 1) ? 1 : $clog2(MAX_DATA_WAIT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_DATA_WAIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              d_misaligned;
  logic              d_rom_req;
  logic              force_d;
  logic              if_win;
  logic              d_win;

  // Grants are gated by reset_n so nothing is accepted while reset is held.
  always_comb begin
    d_misaligned = d_req & (d_addr[1:0] != 2'b00);
    d_rom_req    = d_req & ~d_misaligned;
    force_d      = d_rom_req & (wait_cnt == MAX_CNT);
    if_win       = reset_n & if_req & ~force_d;
    d_win        = reset_n & d_rom_req & (~if_req | force_d);
    if_gnt       = if_win;
    // A misaligned request never touches the ROM, so it can be accepted
    // alongside a fetch.
    d_gnt        = d_win | (reset_n & d_misaligned);
  end

  // With no ROM winner the address is held to avoid needless ROM toggling.
  always_comb begin
    rom_address = addr_q;
    if (if_win) begin
      rom_address = if_addr & WORD_MASK;
    end else if (d_win) begin
      rom_address = d_addr & WORD_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= rom_address;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A flushed fetch leaves if_rdata untouched as well as suppressing rvalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= if_gnt & ~if_flush;
      if (if_gnt && !if_flush) begin
        if_rdata <= rom_data;
      end
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & d_misaligned;
      if (d_gnt) begin
        d_rdata <= d_misaligned ? 32'h0 : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_flush;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] rom_address;
  logic [31:0]       rom_data;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [31:0]       if_q[$];
  logic [32:0]       d_q[$];
  logic [31:0]       if_hold;
  logic [31:0]       d_hold;
  logic [ADDR_W-1:0] last_ra;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int idx);
    logic [31:0] v;
    v = 32'h9E3779B9 * (idx + 1);
    return v ^ 32'h00A5_0000;
  endfunction

  assign rom_data = rom(int'(rom_address >> 2));

  rom_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_WAIT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_address(rom_address), .rom_data(rom_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle with inputs already driven: check the responses due now,
  // the grants and counter, then queue the responses the grants imply.
  task automatic cycle(input bit eg_if, input bit eg_d, input int wc);
    logic        ev;
    logic [32:0] de;
    logic        mis;
    @(negedge clk);
    ev = 1'b0;
    if (if_q.size() > 0) begin
      if_hold = if_q.pop_front();
      ev = 1'b1;
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(ev));
    chk("if_rdata", if_rdata, if_hold);
    ev = 1'b0;
    de = '0;
    if (d_q.size() > 0) begin
      de = d_q.pop_front();
      d_hold = de[31:0];
      ev = 1'b1;
    end
    chk("d_rvalid", 32'(d_rvalid), 32'(ev));
    chk("d_err", 32'(d_err), 32'(de[32]));
    chk("d_rdata", d_rdata, d_hold);
    chk("if_gnt", 32'(if_gnt), 32'(eg_if));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("wait_cnt", 32'(dut.wait_cnt), 32'(wc));
    mis = (d_addr[1:0] != 2'b00);
    if (eg_if) last_ra = {if_addr[ADDR_W-1:2], 2'b00};
    else if (eg_d && !mis) last_ra = {d_addr[ADDR_W-1:2], 2'b00};
    chk("rom_address", 32'(rom_address), 32'(last_ra));
    if (eg_if && !if_flush) if_q.push_back(rom(int'(if_addr >> 2)));
    if (eg_d) d_q.push_back(mis ? {1'b1, 32'h0} : {1'b0, rom(int'(d_addr >> 2))});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_d_err"}, 32'(d_err), 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    chk({tag, "_wait_cnt"}, 32'(dut.wait_cnt), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    if_req   = 1'b1;
    if_addr  = 12'h000;
    if_flush = 1'b0;
    d_req    = 1'b1;
    d_addr   = 12'h010;
    if_hold  = '0;
    d_hold   = '0;
    last_ra  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // fetch-only stream
    if_req = 1'b1; if_addr = 12'h000; cycle(1, 0, 0);
    if_addr = 12'h004; cycle(1, 0, 0);
    if_addr = 12'h008; cycle(1, 0, 0);
    if_req = 1'b0; cycle(0, 0, 0);

    // contention: data forced through on the fourth cycle
    if_req = 1'b1; if_addr = 12'h100; d_req = 1'b1; d_addr = 12'h010;
    cycle(1, 0, 0);
    if_addr = 12'h104; cycle(1, 0, 1);
    if_addr = 12'h108; cycle(1, 0, 2);
    if_addr = 12'h10C; if_flush = 1'b1; cycle(0, 1, 3);
    d_req = 1'b0; if_flush = 1'b0; cycle(1, 0, 0);
    if_req = 1'b0; cycle(0, 0, 0);

    // data alone wins immediately
    d_req = 1'b1; d_addr = 12'h7FC; cycle(0, 1, 0);
    d_req = 1'b0; cycle(0, 0, 0);

    // misaligned data alongside a fetch
    if_req = 1'b1; if_addr = 12'h020; d_req = 1'b1; d_addr = 12'h013;
    cycle(1, 1, 0);
    if_req = 1'b0; d_req = 1'b0; cycle(0, 0, 0);

    // flush
    if_req = 1'b1; if_addr = 12'h040; if_flush = 1'b1; cycle(1, 0, 0);
    if_addr = 12'h044; if_flush = 1'b0; cycle(1, 0, 0);
    if_req = 1'b0; cycle(0, 0, 0);

    // reset while a response is in flight and the counter is nonzero
    if_req = 1'b1; if_addr = 12'h200; d_req = 1'b1; d_addr = 12'h030;
    cycle(1, 0, 0);
    reset_n = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    if_q.delete();
    d_q.delete();
    if_hold = '0;
    d_hold  = '0;
    last_ra = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 12'h000; cycle(1, 0, 0);
    if_req = 1'b0; cycle(0, 0, 0);

    // idle
    repeat (5) cycle(0, 0, 0);

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
